// File: rtl/tdm_pkg.sv
// Shared definitions for the 4:1 TDM multiplex/demultiplex path.
// No logic here: only state encoding and channel-count constants.
// No flow control: these are constants only.
package tdm_pkg;

  localparam int TDM_CHANNELS = 4;
  localparam int TDM_SEL_W    = 2;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } tdm_state_t;

endpackage

// File: rtl/tdm_demux_1x4.sv
// Four-channel TDM demultiplexer: the frame marker on channel 0 aligns the slot counter, and complete frames are presented in parallel.
// Latency: y0..y3 and frame_valid are visible one cycle after the channel-3 sample is taken.
// No backpressure: din_valid gaps stall the slot counter, and every valid sample is consumed or dropped.
module tdm_demux_1x4
  import tdm_pkg::*;
#(
  parameter int W = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [W-1:0]         din,
  input  logic                 din_valid,
  input  logic                 frame_sync,
  output logic [W-1:0]         y0,
  output logic [W-1:0]         y1,
  output logic [W-1:0]         y2,
  output logic [W-1:0]         y3,
  output logic                 frame_valid,
  output logic [TDM_SEL_W-1:0] sel,
  output logic                 locked,
  output logic                 sync_err
);

  tdm_state_t state;

  // Holds channels 0..2 of the frame in progress. Channel 3 goes straight
  // from din to y3, so it needs no shadow slot.
  logic [W-1:0] shadow [0:TDM_CHANNELS-2];

  // The state register drives locked directly, so locked is registered too.
  assign locked = (state == LOCK);

  // Framing FSM, slot counter, shadow capture and atomic output update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      sel         <= '0;
      y0          <= '0;
      y1          <= '0;
      y2          <= '0;
      y3          <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      for (int i = 0; i < TDM_CHANNELS - 1; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (din_valid) begin
        case (state)
          HUNT: begin
            if (frame_sync) begin
              shadow[0] <= din;
              sel       <= 2'd1;
              state     <= LOCK;
            end
          end
          LOCK: begin
            if (frame_sync) begin
              // A sync at slot 0 is normal. At any other slot it is an
              // early sync: the partial frame is abandoned, and because the
              // shadow slots are simply overwritten, no explicit clear is needed.
              sync_err  <= (sel != 2'd0);
              shadow[0] <= din;
              sel       <= 2'd1;
            end else if (sel == 2'd0) begin
              // A missing sync means alignment is lost, so hunt again.
              sync_err <= 1'b1;
              sel      <= 2'd0;
              state    <= HUNT;
            end else if (sel == 2'd3) begin
              y0          <= shadow[0];
              y1          <= shadow[1];
              y2          <= shadow[2];
              y3          <= din;
              frame_valid <= 1'b1;
              sel         <= 2'd0;
            end else begin
              shadow[sel] <= din;
              sel         <= sel + 2'd1;
            end
          end
          default: begin
            state <= HUNT;
            sel   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Testbench for tdm_demux_1x4 with W=4: directed framing scenarios followed by random traffic.
// The reference model collects samples into a queue and is checked on every cycle.
// No backpressure is present.
module tb_tdm_demux_1x4;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         frame_sync;
  logic [W-1:0] y0, y1, y2, y3;
  logic         frame_valid;
  logic [1:0]   sel;
  logic         locked;
  logic         sync_err;

  int checks   = 0;
  int failures = 0;

  // Reference model: a queue of the samples in the current frame plus a hunting flag.
  bit           m_hunt;
  logic [W-1:0] m_q [$];
  logic [W-1:0] m_y [4];
  bit           m_fv;
  bit           m_err;

  tdm_demux_1x4 #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .frame_sync  (frame_sync),
    .y0          (y0),
    .y1          (y1),
    .y2          (y2),
    .y3          (y3),
    .frame_valid (frame_valid),
    .sel         (sel),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input bit s, input logic [W-1:0] d);
    m_fv  = 0;
    m_err = 0;
    if (r) begin
      m_hunt = 1;
      m_q.delete();
      for (int i = 0; i < 4; i++) m_y[i] = '0;
    end else if (v) begin
      if (m_hunt) begin
        if (s) begin
          m_hunt = 0;
          m_q.delete();
          m_q.push_back(d);
        end
      end else if (s) begin
        if (m_q.size() != 0) m_err = 1;
        m_q.delete();
        m_q.push_back(d);
      end else if (m_q.size() == 0) begin
        m_err  = 1;
        m_hunt = 1;
      end else begin
        m_q.push_back(d);
        if (m_q.size() == 4) begin
          for (int i = 0; i < 4; i++) m_y[i] = m_q[i];
          m_fv = 1;
          m_q.delete();
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".y0"}, 8'(y0), 8'(m_y[0]));
    chk({tag, ".y1"}, 8'(y1), 8'(m_y[1]));
    chk({tag, ".y2"}, 8'(y2), 8'(m_y[2]));
    chk({tag, ".y3"}, 8'(y3), 8'(m_y[3]));
    chk({tag, ".frame_valid"}, 8'(frame_valid), 8'(m_fv));
    chk({tag, ".sync_err"}, 8'(sync_err), 8'(m_err));
    chk({tag, ".locked"}, 8'(locked), 8'(!m_hunt));
    chk({tag, ".sel"}, 8'(sel), 8'(m_q.size()));
  endtask

  // Drives one cycle of inputs, then checks every output after the active edge.
  task automatic cyc(input string tag, input bit r, input bit v, input bit s, input logic [W-1:0] d);
    rst        = r;
    din_valid  = v;
    frame_sync = s;
    din        = d;
    @(posedge clk);
    #1;
    model_step(r, v, s, d);
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 0, 0, 0, 4'h0);
  endtask

  initial begin
    rst = 1; din = '0; din_valid = 0; frame_sync = 0;
    m_hunt = 1; m_fv = 0; m_err = 0;
    for (int i = 0; i < 4; i++) m_y[i] = '0;
    #2;

    // Reset state, with inputs active during reset to confirm that reset has priority.
    cyc("reset", 1, 1, 1, 4'h7);
    cyc("reset2", 1, 0, 0, 4'h0);
    chk("reset.locked_const", 8'(locked), 8'h0);

    // Full-rate frame A,B,C,D.
    cyc("f1", 0, 1, 1, 4'hA);
    cyc("f1", 0, 1, 0, 4'hB);
    cyc("f1", 0, 1, 0, 4'hC);
    cyc("f1", 0, 1, 0, 4'hD);
    chk("f1.fv_abs", 8'(frame_valid), 8'h1);
    chk("f1.y_abs", 8'({y0, y1}), 8'hAB);
    idle("f1.idle", 1);

    // After reset, samples without sync are dropped; then frame 5,6,7,8.
    cyc("h.rst", 1, 0, 0, 4'h0);
    cyc("h", 0, 1, 0, 4'h1);
    cyc("h", 0, 1, 0, 4'h2);
    chk("h.locked_abs", 8'(locked), 8'h0);
    cyc("h", 0, 1, 1, 4'h5);
    cyc("h", 0, 1, 0, 4'h6);
    cyc("h", 0, 1, 0, 4'h7);
    cyc("h", 0, 1, 0, 4'h8);
    chk("h.y3_abs", 8'(y3), 8'h8);

    // Gaps of 0, 2 and 3 invalid cycles between samples.
    cyc("gap", 0, 1, 1, 4'h1);
    cyc("gap", 0, 1, 0, 4'h2);
    idle("gap", 2);
    cyc("gap", 0, 1, 0, 4'h3);
    idle("gap", 3);
    cyc("gap", 0, 1, 0, 4'h4);
    idle("gap", 2);

    // Early sync: sync 9, A, then sync 1,2,3,4.
    cyc("early", 0, 1, 1, 4'h9);
    cyc("early", 0, 1, 0, 4'hA);
    cyc("early", 0, 1, 1, 4'h1);
    chk("early.err_abs", 8'(sync_err), 8'h1);
    cyc("early", 0, 1, 0, 4'h2);
    cyc("early", 0, 1, 0, 4'h3);
    cyc("early", 0, 1, 0, 4'h4);

    // Missing sync after a completed frame.
    cyc("miss", 0, 1, 0, 4'hF);
    chk("miss.err_abs", 8'(sync_err), 8'h1);
    idle("miss", 1);

    // Reset in mid-frame, then the remaining samples arrive.
    cyc("mid", 0, 1, 1, 4'h3);
    cyc("mid", 0, 1, 0, 4'h4);
    cyc("mid", 1, 0, 0, 4'h0);
    cyc("mid", 0, 1, 0, 4'h5);
    cyc("mid", 0, 1, 0, 4'h6);
    chk("mid.fv_abs", 8'(frame_valid), 8'h0);

    // Random traffic biased toward well-formed frames.
    for (int n = 0; n < 3000; n++) begin
      bit r, v, s;
      r = ($urandom_range(0, 399) == 0);
      v = ($urandom_range(0, 3) != 0);
      if (!m_hunt && m_q.size() == 0) s = ($urandom_range(0, 7) != 0);
      else s = ($urandom_range(0, 9) == 0);
      cyc("rand", r, v, s, 4'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdm_demux_1x4.md
# tdm_demux_1x4

Four-channel time-division demultiplexer, the receiving end of the 4:1 multiplexer path. It takes a single time-multiplexed sample stream with a frame marker on channel 0 and tracks the channel slot with an internal counter. It reassembles each frame of four samples and presents all four channels on parallel outputs, updated atomically once per completed frame. It sits between the serial link and per-channel consumers in the datapath.

## Interface
- `W`, default 1: sample width in bits.

- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `din` in W: multiplexed sample.
- `din_valid` in 1: `din` holds a sample this cycle.
- `frame_sync` in 1: qualifies a valid sample as channel 0; ignored when `din_valid`=0.
- `y0`, `y1`, `y2`, `y3` out W each: channel outputs from the last completed frame.
- `frame_valid` out 1: one-cycle pulse when `y0`..`y3` have just been updated.
- `sel` out 2: channel index the next valid sample will be written to.
- `locked` out 1: 1 in state LOCK.
- `sync_err` out 1: one-cycle pulse on a framing violation.

## Operation
- States:
  - HUNT: reset state, waiting for a sync.
  - LOCK: tracking frames.
- Channel counter `sel` is 2 bits and wraps 3→0 naturally.
- In HUNT:
  - Valid sample with `frame_sync`=0: dropped, no other effect.
  - Valid sample with `frame_sync`=1: stored to shadow ch0, `sel`←1, go to LOCK.
- In LOCK, for each valid sample:
  - `sel`=0 and `frame_sync`=1: store to shadow ch0, `sel`←1.
  - `sel`=1 or 2 and `frame_sync`=0: store to shadow[`sel`], `sel`++.
  - `sel`=3 and `frame_sync`=0:
    - Load `y0`..`y2` from shadow and `y3` from `din` in the same edge.
    - Pulse `frame_valid` next cycle.
    - `sel`←0.
  - `sel`≠0 and `frame_sync`=1 (early sync):
    - Pulse `sync_err` and discard the partial frame.
    - Treat the sample as channel 0: store to shadow ch0, `sel`←1, stay in LOCK.
  - `sel`=0 and `frame_sync`=0 (missing sync):
    - Pulse `sync_err` and drop the sample.
    - `sel`←0, go to HUNT.
- Cycles with `din_valid`=0: no state, counter or shadow change; gaps are allowed anywhere in a frame.
- `y0`..`y3` change only on frame completion, never on a partial frame.
- Reset values:
  - state HUNT, `sel`=0.
  - `y0`..`y3`=0, shadow=0.
  - `frame_valid`=0, `sync_err`=0, `locked`=0.
- Reset mid-frame: the partial frame is discarded and outputs clear to 0 on the reset edge.

## Timing
- All outputs are registered.
- Latency: the edge that samples the channel-3 sample updates `y0`..`y3` and `frame_valid`, so both are visible in the following cycle.
- `frame_valid` and `sync_err` are single-cycle pulses. They are never asserted together, since a frame cannot complete on an error sample.
- `sel` and `locked` reflect the post-edge state.
- Back-to-back frames at full rate (4 valid cycles each) give one `frame_valid` every 4 cycles.
- A sync on the sample immediately after channel 3 is normal operation, not an error.
- `rst` has priority over every input in the same cycle.

## Structure
- Shared package `tdm_pkg`:
  - State encoding: HUNT=1'b0, LOCK=1'b1.
  - `TDM_CHANNELS`=4.
  - `TDM_SEL_W`=2.
- Single module. No sub-module is needed: the counter, FSM and shadow/output registers are one tightly coupled unit.

## Test plan
- W=4, reset then frame {sync:0xA, 0xB, 0xC, 0xD} at full rate → `frame_valid` 1 cycle after 0xD is sampled, `y0..y3`=A,B,C,D, `sync_err`=0.
- Valid samples 0x1, 0x2 with no sync after reset → stays HUNT, `locked`=0, `y*`=0, no pulses; then sync frame 5,6,7,8 → `y*`=5,6,7,8.
- Frame 1,2,3,4 with `din_valid` gaps of 0, 2 and 3 cycles between samples → `y*`=1,2,3,4, exactly one `frame_valid`.
- Locked; samples sync:9, A, then sync:1, 2, 3, 4 → one `sync_err` at the second sync, `y*` keeps the prior values until 1,2,3,4 completes, then `y*`=1,2,3,4.
- Locked after a frame; next valid sample 0xF without sync → `sync_err` pulse, `locked`=0, `sel`=0, `y*` unchanged.
- `rst` asserted after samples ch0 and ch1 of a frame → all outputs 0, HUNT; completing samples ch2 and ch3 alone produce no `frame_valid`.
